// File: rtl/dnl_master.sv
// Multi-lane serial frame master: clamps/pads a payload and shifts it out MSB-first over LANES lines.
// Optional trailing even-parity beat per lane is enabled with the D2L_PARITY_EN macro.
module dnl_master #(
   parameter int DATA_WIDTH = 64,
   parameter int LANES      = 2,
   parameter int CLK_DIV    = 2,
   localparam int WW        = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WW-1:0]         in_width,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  sclk,
   output logic                  CS,
   output logic [LANES-1:0]      data_line,
   output logic                  busy,
   output logic                  done
);

   localparam int WP = WW + 1;
   localparam int BW = $clog2(DATA_WIDTH / LANES + 2);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

`ifdef D2L_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, HOLD, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
`endif

   state_t                state;
   logic [BW-1:0]         beat_cnt;
   logic [CW-1:0]         cnt;
   logic [WW-1:0]         w_eff;
   logic [WP-1:0]         w_round;
   logic [WP-1:0]         pad_shift;
   logic [BW-1:0]         beats;
   logic [DATA_WIDTH-1:0] padded;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  accept;
   logic                  fall;

   // Left-align the zero-padded payload so beat 0 always sits in the top LANES bits.
   always_comb begin
      w_eff     = (in_width > WW'(DATA_WIDTH)) ? WW'(DATA_WIDTH) : in_width;
      w_round   = {1'b0, w_eff} + WP'(LANES - 1);
      beats     = BW'(w_round / WP'(LANES));
      pad_shift = WP'(DATA_WIDTH) - (w_round & ~WP'(LANES - 1));
      padded    = (in_data & ~({DATA_WIDTH{1'b1}} << w_eff)) << pad_shift;
      accept    = in_valid && in_ready && (w_eff != '0);
      fall      = (state == SHIFT) && sclk && (cnt == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (accept)
         shreg <= padded << LANES;
      else if (fall)
         shreg <= shreg << LANES;
   end

`ifdef D2L_PARITY_EN
   logic [LANES-1:0] par;

   always_ff @(posedge clk) begin
      if (accept)
         par <= '0;
      else if (fall)
         par <= par ^ data_line;
   end
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         sclk      <= 1'b0;
         CS        <= 1'b1;
         data_line <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         in_ready  <= 1'b0;
         beat_cnt  <= '0;
         cnt       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  if (w_eff == '0) begin
                     done <= 1'b1;
                  end else begin
                     state     <= SHIFT;
                     busy      <= 1'b1;
                     CS        <= 1'b0;
                     in_ready  <= 1'b0;
                     sclk      <= 1'b0;
                     data_line <= padded[DATA_WIDTH-1 -: LANES];
                     beat_cnt  <= beats;
                     cnt       <= '0;
                  end
               end
            end
`ifdef D2L_PARITY_EN
            SHIFT, PARITY: begin
`else
            SHIFT: begin
`endif
               if (cnt == CNT_LAST) begin
                  cnt  <= '0;
                  sclk <= !sclk;
                  // Data only advances when sclk falls, so it is stable across each rise.
                  if (sclk) begin
                     if (state == SHIFT && beat_cnt != BW'(1)) begin
                        beat_cnt  <= beat_cnt - BW'(1);
                        data_line <= shreg[DATA_WIDTH-1 -: LANES];
                     end
`ifdef D2L_PARITY_EN
                     else if (state == SHIFT) begin
                        state     <= PARITY;
                        data_line <= par ^ data_line;
                     end
`endif
                     else begin
                        state     <= HOLD;
                        data_line <= '0;
                     end
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            HOLD: begin
               if (cnt == CNT_LAST) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  CS       <= 1'b1;
                  done     <= 1'b1;
                  in_ready <= 1'b1;
                  cnt      <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dnl_master.sv
// Bench for dnl_master: per-cycle comparison against a timeline model plus directed literal frames.
// Builds with or without D2L_PARITY_EN.
module tb_dnl_master;
   localparam int DW = 64;
   localparam int L  = 2;
   localparam int CD = 2;
   localparam int WW = 7;
`ifdef D2L_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic          in_valid = 1'b0;
   logic [WW-1:0] in_width = '0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready, sclk, CS, busy, done;
   logic [L-1:0]  data_line;

   int errors = 0;
   int checks = 0;

   dnl_master #(.DATA_WIDTH(DW), .LANES(L), .CLK_DIV(CD)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .in_width(in_width), .in_data(in_data), .sclk(sclk), .CS(CS),
      .data_line(data_line), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a frame is a list of beats; outputs are a function of edges elapsed since acceptance.
   bit           m_active = 0, m_ready = 0, m_done = 0;
   int           m_n = 0, m_B = 0;
   logic [L-1:0] m_beats[$];

   function automatic void build(input int w_in, input logic [DW-1:0] d);
      int w;
      logic [L-1:0] v;
      w = (w_in > DW) ? DW : w_in;
      m_B = (w + L - 1) / L;
      m_beats.delete();
      for (int b = 0; b < m_B; b++) begin
         v = '0;
         for (int l = 0; l < L; l++) begin
            int idx = (m_B - 1 - b) * L + l;
            if (idx < w) v[l] = d[idx];
         end
         m_beats.push_back(v);
      end
`ifdef D2L_PARITY_EN
      if (m_B > 0) begin
         logic [L-1:0] p = '0;
         foreach (m_beats[i]) p ^= m_beats[i];
         m_beats.push_back(p);
         m_B++;
      end
`endif
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_active = 0; m_ready = 0; m_done = 0;
      end else begin
         m_done = 0;
         if (m_active) begin
            m_n++;
            if (m_n == (2 * m_B + 1) * CD) begin
               m_active = 0; m_done = 1; m_ready = 1;
            end
         end else if (in_valid && m_ready) begin
            build(int'(in_width), in_data);
            if (m_B == 0) m_done = 1;
            else begin
               m_active = 1; m_n = 0; m_ready = 0;
            end
         end else begin
            m_ready = 1;
         end
      end
   end

   always @(negedge clk) begin : mon
      logic e_sclk, e_cs, e_busy, e_done, e_ready;
      logic [L-1:0] e_data;
      e_sclk = 0; e_cs = 1; e_busy = 0; e_done = m_done; e_ready = m_ready; e_data = '0;
      if (m_active) begin
         e_cs = 0; e_busy = 1; e_done = 0; e_ready = 0;
         if (m_n < 2 * m_B * CD) begin
            e_sclk = ((m_n / CD) % 2) == 1;
            e_data = m_beats[m_n / (2 * CD)];
         end
      end
      check("mon_sclk", sclk, e_sclk);
      check("mon_cs", CS, e_cs);
      check("mon_data", data_line, e_data);
      check("mon_busy", busy, e_busy);
      check("mon_done", done, e_done);
      check("mon_ready", in_ready, e_ready);
   end

   logic [L-1:0] rise_q[$];
   int           done_k, cslow;
   logic         cs_first;

   task automatic launch(input int w, input logic [DW-1:0] d, input bit hold);
      int waited = 0;
      @(negedge clk);
      in_width = WW'(w); in_data = d; in_valid = 1'b1;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("accept_wait", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = hold; in_data = ~d; in_width = WW'(5);
   endtask

   task automatic collect(input int budget);
      logic prev = 1'b0;
      rise_q.delete(); cslow = 0; done_k = -1; cs_first = 1'b1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (k == 0) cs_first = CS;
         if (!CS) cslow++;
         if (sclk && !prev) rise_q.push_back(data_line);
         prev = sclk;
         if (done) begin
            done_k = k;
            break;
         end
         @(posedge clk);
      end
   endtask

   function automatic longint pack(input int n);
      longint v = 0;
      for (int i = 0; i < n; i++)
         v = (v << L) | longint'((i < rise_q.size()) ? rise_q[i] : '0);
      return v;
   endfunction

   initial begin
      #2 rstn = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_cs", CS, 1);
      check("rst_sclk", sclk, 0);
      check("rst_data", data_line, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", in_ready, 0);
      rstn = 1'b1;
      @(negedge clk);
      check("ready_after_rst", in_ready, 1);

      launch(8, 64'hA5, 0); collect(300);
      check("a5_nbeats", rise_q.size(), 4 + PB);
      check("a5_beats", pack(4), 'hA5);
      check("a5_done", done_k, 18 + 4 * PB);
      check("a5_cslow", cslow, 18 + 4 * PB);

      launch(3, 64'h5, 0); collect(300);
      check("w3_nbeats", rise_q.size(), 2 + PB);
      check("w3_beats", pack(2), 'h5);
      check("w3_done", done_k, 10 + 4 * PB);

      launch(100, 64'h0123456789ABCDEF, 0); collect(400);
      check("w100_nbeats", rise_q.size(), 32 + PB);
      check("w100_beats", pack(32), 64'h0123456789ABCDEF);
      check("w100_done", done_k, 130 + 4 * PB);

      launch(0, 64'hFF, 0); collect(50);
      check("w0_done", done_k, 0);
      check("w0_cslow", cslow, 0);
      check("w0_nbeats", rise_q.size(), 0);

`ifdef D2L_PARITY_EN
      launch(8, 64'hA4, 0); collect(300);
      check("par_nbeats", rise_q.size(), 5);
      check("par_beats", pack(5), 'h291);
      check("par_done", done_k, 22);
`endif

      launch(8, 64'hA5, 0);
      repeat (7) @(posedge clk);
      #1 rstn = 1'b0;
      #1;
      check("abort_cs", CS, 1);
      check("abort_sclk", sclk, 0);
      check("abort_data", data_line, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      launch(8, 64'h3C, 0); collect(300);
      check("post_rst_beats", pack(4), 'h3C);
      check("post_rst_done", done_k, 18 + 4 * PB);

      launch(8, 64'hA5, 1); collect(300);
      check("b2b1_beats", pack(4), 'hA5);
      check("b2b1_done", done_k, 18 + 4 * PB);
      check("b2b_cs_gap", CS, 1);
      check("b2b_ready", in_ready, 1);
      in_data = 64'h3C; in_width = WW'(8);
      @(posedge clk);
      #1 in_valid = 1'b0; in_data = '0;
      collect(300);
      check("b2b2_cs_first", cs_first, 0);
      check("b2b2_beats", pack(4), 'h3C);
      check("b2b2_done", done_k, 18 + 4 * PB);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
